// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with beq/bne branch resolution, feeding the EX/MEM pipeline register.
// The register supports stall (hold) and flush (bubble); unsupported ALU codes are flagged and neutralised.
module ex_alu_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    input  logic            Stall,
    input  logic            Flush,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Branch,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] BranchTargetIn,
    input  logic [XLEN-1:0] StoreDataIn,
    input  logic [4:0]      RdIn,
    input  logic            RegWriteIn,
    input  logic            MemReadIn,
    input  logic            MemWriteIn,
    output logic            OutValid,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            BranchTaken,
    output logic [XLEN-1:0] BranchTarget,
    output logic [XLEN-1:0] StoreData,
    output logic [4:0]      RdOut,
    output logic            RegWriteOut,
    output logic            MemReadOut,
    output logic            MemWriteOut,
    output logic            IllegalOp
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] result;
        logic            zero;
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;

    logic [SHAMT_W-1:0] shamt_s;
    logic [XLEN-1:0]    alu_result_s;
    logic               illegal_s;
    logic               zero_s;
    logic               taken_s;
    ex_mem_t            load_s;
    ex_mem_t            ex_mem_r;

    assign shamt_s = SrcB[SHAMT_W-1:0];

    // ALU datapath: result of the selected operation, illegal codes yield zero
    always_comb begin
        alu_result_s = {XLEN{1'b0}};
        illegal_s    = 1'b0;
        case (ALUControl)
            OP_AND:  alu_result_s = SrcA & SrcB;
            OP_OR:   alu_result_s = SrcA | SrcB;
            OP_ADD:  alu_result_s = SrcA + SrcB;
            OP_SUB:  alu_result_s = SrcA - SrcB;
            OP_SLL:  alu_result_s = SrcA << shamt_s;
            OP_SRL:  alu_result_s = SrcA >> shamt_s;
            OP_SRA:  alu_result_s = $unsigned($signed(SrcA) >>> shamt_s);
            default: begin
                alu_result_s = {XLEN{1'b0}};
                illegal_s    = 1'b1;
            end
        endcase
    end

    assign zero_s = (alu_result_s == {XLEN{1'b0}});

    // Branch resolution: beq/bne only, never taken on an illegal operation
    always_comb begin
        taken_s = 1'b0;
        if (Branch && !illegal_s) begin
            case (Funct3)
                F3_BEQ:  taken_s = zero_s;
                F3_BNE:  taken_s = !zero_s;
                default: taken_s = 1'b0;
            endcase
        end else begin
            taken_s = 1'b0;
        end
    end

    // Next-slot contents for a valid instruction; side-effecting controls are killed on illegal ops
    always_comb begin
        load_s            = EX_MEM_BUBBLE;
        load_s.valid      = 1'b1;
        load_s.result     = alu_result_s;
        load_s.zero       = zero_s;
        load_s.taken      = taken_s;
        load_s.target     = BranchTargetIn;
        load_s.store_data = StoreDataIn;
        load_s.rd         = RdIn;
        load_s.reg_write  = RegWriteIn & !illegal_s;
        load_s.mem_read   = MemReadIn & !illegal_s;
        load_s.mem_write  = MemWriteIn & !illegal_s;
        load_s.illegal    = illegal_s;
    end

    // EX/MEM register: reset > flush > stall > load/bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_r <= EX_MEM_BUBBLE;
        end else if (Flush) begin
            ex_mem_r <= EX_MEM_BUBBLE;
        end else if (Stall) begin
            ex_mem_r <= ex_mem_r;
        end else if (InValid) begin
            ex_mem_r <= load_s;
        end else begin
            ex_mem_r <= EX_MEM_BUBBLE;
        end
    end

    assign OutValid     = ex_mem_r.valid;
    assign ALUResult    = ex_mem_r.result;
    assign Zero         = ex_mem_r.zero;
    assign BranchTaken  = ex_mem_r.taken;
    assign BranchTarget = ex_mem_r.target;
    assign StoreData    = ex_mem_r.store_data;
    assign RdOut        = ex_mem_r.rd;
    assign RegWriteOut  = ex_mem_r.reg_write;
    assign MemReadOut   = ex_mem_r.mem_read;
    assign MemWriteOut  = ex_mem_r.mem_write;
    assign IllegalOp    = ex_mem_r.illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: vector table for single-cycle ops plus stall/flush/reset sequences.
module tb_ex_alu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid, Stall, Flush;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic        Branch;
    logic [2:0]  Funct3;
    logic [31:0] BranchTargetIn, StoreDataIn;
    logic [4:0]  RdIn;
    logic        RegWriteIn, MemReadIn, MemWriteIn;
    logic        OutValid;
    logic [31:0] ALUResult;
    logic        Zero, BranchTaken;
    logic [31:0] BranchTarget, StoreData;
    logic [4:0]  RdOut;
    logic        RegWriteOut, MemReadOut, MemWriteOut, IllegalOp;

    int checks = 0;
    int errors = 0;

    ex_alu_stage #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .Stall(Stall), .Flush(Flush),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .Branch(Branch), .Funct3(Funct3),
        .BranchTargetIn(BranchTargetIn), .StoreDataIn(StoreDataIn), .RdIn(RdIn),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .OutValid(OutValid), .ALUResult(ALUResult), .Zero(Zero), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .StoreData(StoreData), .RdOut(RdOut),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic [2:0]  f3;
        logic        vin;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        zero;
        logic        taken;
        logic        valid;
        logic        ill;
        logic        erw;
        logic        emr;
        logic        emw;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic br, input logic [2:0] f3, input logic vin,
                         input logic rw, input logic mr, input logic mw, input logic [4:0] rd);
        ALUControl = ctrl; SrcA = a; SrcB = b; Branch = br; Funct3 = f3; InValid = vin;
        RegWriteIn = rw; MemReadIn = mr; MemWriteIn = mw; RdIn = rd;
        BranchTargetIn = a ^ 32'h0000_1000;
        StoreDataIn    = b ^ 32'h5A5A_0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name);
        check({name, ".valid"}, {31'd0, OutValid}, 32'd0);
        check({name, ".result"}, ALUResult, 32'd0);
        check({name, ".zero"}, {31'd0, Zero}, 32'd0);
        check({name, ".taken"}, {31'd0, BranchTaken}, 32'd0);
        check({name, ".ctl"}, {26'd0, RdOut, RegWriteOut, MemReadOut, MemWriteOut, IllegalOp}, 32'd0);
        check({name, ".pass"}, BranchTarget | StoreData, 32'd0);
    endtask

    initial begin
        //            ctrl     a             b             br    f3      vin   rw    mr    mw    rd     res           z     tk    v     ill   erw   emr   emw
        vecs[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1,  32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0110, 32'h00001234, 32'h00001234, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0110, 32'h00001234, 32'h00001234, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0110, 32'h00001234, 32'h00001234, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0101, 32'h80000000, 32'h00000024, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4,  32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0100, 32'h80000000, 32'h00000024, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  32'h08000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'b0011, 32'h00000001, 32'h00000024, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6,  32'h00000010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'b0000, 32'h000000F0, 32'h0000003C, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7,  32'h00000030, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'b0001, 32'h000000F0, 32'h0000003C, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8,  32'h000000FC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0110, 32'h00000005, 32'h00000007, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b1111, 32'h00000005, 32'h00000003, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b0010, 32'h00000005, 32'h00000003, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0010, 32'h0000000A, 32'h00000014, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0000001E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{4'b0111, 32'h00000000, 32'h00000000, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(4'b0010, 32'd1, 32'd2, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3);
        step();
        step();
        check_bubble("reset");
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].f3, vecs[i].vin,
                  vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].rd);
            step();
            check($sformatf("v%0d.result", i), ALUResult, vecs[i].res);
            check($sformatf("v%0d.flags", i), {27'd0, OutValid, Zero, BranchTaken, IllegalOp, 1'b0},
                  {27'd0, vecs[i].valid, vecs[i].zero, vecs[i].taken, vecs[i].ill, 1'b0});
            check($sformatf("v%0d.ctl", i), {29'd0, RegWriteOut, MemReadOut, MemWriteOut},
                  {29'd0, vecs[i].erw, vecs[i].emr, vecs[i].emw});
            check($sformatf("v%0d.rd", i), {27'd0, RdOut}, vecs[i].valid ? {27'd0, vecs[i].rd} : 32'd0);
            check($sformatf("v%0d.target", i), BranchTarget,
                  vecs[i].valid ? (vecs[i].a ^ 32'h0000_1000) : 32'd0);
            check($sformatf("v%0d.store", i), StoreData,
                  vecs[i].valid ? (vecs[i].b ^ 32'h5A5A_0000) : 32'd0);
        end

        // Stall holds a loaded add across changing inputs, then Flush overrides Stall
        drive(4'b0010, 32'd5, 32'd3, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9);
        step();
        check("stall.load", ALUResult, 32'd8);
        Stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0110, 32'd100 + c, 32'd100 + c, 1'b1, 3'b000, c[0], 1'b0, 1'b1, 1'b1, 5'd20);
            step();
            check($sformatf("stall%0d.result", c), ALUResult, 32'd8);
            check($sformatf("stall%0d.flags", c), {28'd0, OutValid, Zero, BranchTaken, RegWriteOut},
                  {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
            check($sformatf("stall%0d.rd", c), {27'd0, RdOut}, 32'd9);
        end
        Flush = 1'b1;
        step();
        check_bubble("stall_flush");
        Flush = 1'b0; Stall = 1'b0;

        // Flush alone with a valid instruction present inserts a bubble
        drive(4'b0010, 32'd7, 32'd7, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2);
        Flush = 1'b1;
        step();
        check_bubble("flush");
        Flush = 1'b0;

        // Reset while a valid add is held by Stall clears on that edge
        drive(4'b0010, 32'd5, 32'd3, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9);
        step();
        Stall = 1'b1;
        step();
        check("rstall.hold", ALUResult, 32'd8);
        reset = 1'b1;
        step();
        check_bubble("reset_stall");
        reset = 1'b0; Stall = 1'b0;
        drive(4'b0000, 32'h000000F0, 32'h0000003C, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        step();
        check("post_reset.result", ALUResult, 32'h00000030);
        check("post_reset.valid", {30'd0, OutValid, Zero}, {30'd0, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
